// File: rtl/debug_dump_sequencer_if.sv
// Handshake bundle between the dump sequencer, the pipeline database and the UART.
// slave = sequencer side, master = environment (database + UART) side.
interface debug_dump_sequencer_if #(
  parameter int CANT_BITS_CONTROL    = 4,
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int CANT_BITS_UART       = 8
);
  logic                            i_start;
  logic [LONGITUD_INSTRUCCION-1:0] i_dato;
  logic [CANT_BITS_CONTROL-1:0]    o_control;
  logic [CANT_BITS_UART-1:0]       o_tx_data;
  logic                            o_tx_start;
  logic                            i_tx_done;
  logic                            o_busy;
  logic                            o_done;

  modport slave (
    input  i_start, i_dato, i_tx_done,
    output o_control, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport master (
    output i_start, i_dato, i_tx_done,
    input  o_control, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Walks every database word, streaming each one MSB byte first to the UART.
// All outputs come straight from registers, so no input reaches an output combinationally.
module debug_dump_sequencer #(
  parameter int CANT_BITS_CONTROL    = 4,
  parameter int LONGITUD_INSTRUCCION = 32,
  parameter int CANT_PALABRAS        = 12,
  parameter int CANT_BITS_UART       = 8
) (
  input  logic                   i_clock,
  input  logic                   i_soft_reset,
  debug_dump_sequencer_if.slave  bus
);

  localparam int IDX_W  = (CANT_PALABRAS > 1) ? $clog2(CANT_PALABRAS) : 1;
  localparam int BYTES  = LONGITUD_INSTRUCCION / CANT_BITS_UART;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CANT_PALABRAS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, LATCH, SEND, WAIT_TX, NEXT, DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [BCNT_W-1:0]               bcnt_q, bcnt_d;
  logic [LONGITUD_INSTRUCCION-1:0] shift_q, shift_d;
  logic [CANT_BITS_CONTROL-1:0]    ctrl_q, ctrl_d;

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          idx_d   = '0;
          ctrl_d  = '0;
          state_d = SETTLE;
        end
      end
      // one spare cycle so the database output tracks the new select
      SETTLE: state_d = LATCH;
      LATCH: begin
        shift_d = bus.i_dato;
        bcnt_d  = '0;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: begin
        // tx_done only matters here; a pulse during SEND is deliberately dropped
        if (bus.i_tx_done) begin
          if (bcnt_q != LAST_BYTE) begin
            shift_d = shift_q << CANT_BITS_UART;
            bcnt_d  = bcnt_q + BCNT_W'(1);
            state_d = SEND;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          ctrl_d  = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          ctrl_d  = CANT_BITS_CONTROL'(idx_q + IDX_W'(1));
          state_d = SETTLE;
        end
      end
      DONE: begin
        ctrl_d  = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_control  = ctrl_q;
  assign bus.o_tx_data  = shift_q[LONGITUD_INSTRUCCION-1 -: CANT_BITS_UART];
  assign bus.o_tx_start = (state_q == SEND);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = (state_q == DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed-plus-random bench: database array and UART responder live here, expected
// bytes are derived from the database contents word by word, MSB byte first.
module tb_debug_dump_sequencer;
  localparam int CB = 4, LI = 32, CP = 12, CU = 8;

  logic i_clock = 1'b0;
  logic i_soft_reset = 1'b1;
  always #5 i_clock = ~i_clock;

  debug_dump_sequencer_if #(.CANT_BITS_CONTROL(CB), .LONGITUD_INSTRUCCION(LI), .CANT_BITS_UART(CU)) bus ();
  debug_dump_sequencer_if #(.CANT_BITS_CONTROL(CB), .LONGITUD_INSTRUCCION(LI), .CANT_BITS_UART(CU)) bus1 ();

  debug_dump_sequencer #(.CANT_BITS_CONTROL(CB), .LONGITUD_INSTRUCCION(LI),
                         .CANT_PALABRAS(CP), .CANT_BITS_UART(CU)) dut (
    .i_clock(i_clock), .i_soft_reset(i_soft_reset), .bus(bus.slave));

  debug_dump_sequencer #(.CANT_BITS_CONTROL(CB), .LONGITUD_INSTRUCCION(LI),
                         .CANT_PALABRAS(1), .CANT_BITS_UART(CU)) dut1 (
    .i_clock(i_clock), .i_soft_reset(i_soft_reset), .bus(bus1.slave));

  logic [LI-1:0] mem [16];
  logic start = 1'b0, txd = 1'b0, sel = 1'b0;
  int compared = 0, mismatched = 0, pulses = 0, dones = 0;

  assign bus.i_start    = start & ~sel;
  assign bus1.i_start   = start & sel;
  assign bus.i_tx_done  = txd & ~sel;
  assign bus1.i_tx_done = txd & sel;
  assign bus.i_dato     = mem[bus.o_control];
  assign bus1.i_dato    = mem[bus1.o_control];

  logic [CB-1:0] obs_ctl;
  logic [CU-1:0] obs_data;
  logic          obs_tx_start, obs_busy, obs_done;
  assign obs_ctl      = sel ? bus1.o_control  : bus.o_control;
  assign obs_data     = sel ? bus1.o_tx_data  : bus.o_tx_data;
  assign obs_tx_start = sel ? bus1.o_tx_start : bus.o_tx_start;
  assign obs_busy     = sel ? bus1.o_busy     : bus.o_busy;
  assign obs_done     = sel ? bus1.o_done     : bus.o_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every cycle passes through here, so pulse tallies see each cycle exactly once
  task automatic tick();
    @(posedge i_clock);
    #1;
    if (obs_tx_start === 1'b1) pulses++;
    if (obs_done === 1'b1) dones++;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ctl"}, obs_ctl, 0);
    chk({tag, "_data"}, obs_data, 0);
    chk({tag, "_txs"}, obs_tx_start, 0);
    chk({tag, "_busy"}, obs_busy, 0);
    chk({tag, "_done"}, obs_done, 0);
  endtask

  // gap=0 picks a random tx_done delay per byte; *_at arguments are byte numbers (-1 = none)
  task automatic run_dump(input int nwords, input int gap, input int start_at,
                          input int glitch_at, input int reset_at);
    logic [CU-1:0] exp;
    int k, n, g, p;
    pulses = 0;
    dones  = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", obs_busy, 1);
    chk("ctl_after_start", obs_ctl, 0);
    tick(); tick();
    chk("tx_start_latency", obs_tx_start, 1);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) begin
        k   = w * 4 + b;
        exp = CU'(mem[w] >> (24 - 8 * b));
        n = 0;
        while (obs_tx_start !== 1'b1 && n < 40) begin tick(); n++; end
        if (obs_tx_start !== 1'b1) begin
          chk("tx_start_timeout", 0, 1);
          return;
        end
        chk("tx_data", obs_data, exp);
        chk("control", obs_ctl, w);
        if (k == reset_at) begin
          tick(); tick();
          i_soft_reset = 1'b1; tick(); i_soft_reset = 1'b0;
          chk_idle_zero("after_reset");
          p = pulses;
          repeat (20) tick();
          chk("no_tx_after_reset", pulses, p);
          chk("no_done_after_reset", dones, 0);
          chk("idle_after_reset", obs_busy, 0);
          return;
        end
        g = (k == glitch_at) ? 12 : ((gap == 0) ? $urandom_range(1, 6) : gap);
        for (int j = 0; j < g; j++) begin
          txd   = (k == glitch_at && j == 0);
          start = (k == start_at && j == 1);
          tick();
          txd   = 1'b0;
          start = 1'b0;
          chk("no_tx_start_in_wait", obs_tx_start, 0);
          chk("tx_data_stable", obs_data, exp);
          chk("busy_in_wait", obs_busy, 1);
        end
        txd = 1'b1; tick(); txd = 1'b0;
      end
    end
    chk("no_done_in_next", obs_done, 0);
    tick();
    chk("done_pulse", obs_done, 1);
    chk("ctl_at_done", obs_ctl, 0);
    tick();
    chk("done_one_cycle", obs_done, 0);
    chk("busy_after_done", obs_busy, 0);
    repeat (5) tick();
    chk("pulse_count", pulses, 4 * nwords);
    chk("done_count", dones, 1);
  endtask

  initial begin
    mem[0] = 32'h0A0B0C0D;
    for (int i = 1; i < 16; i++) mem[i] = $urandom;

    repeat (3) tick();
    i_soft_reset = 1'b0;
    chk_idle_zero("reset_state");

    // start coincident with reset must not launch a dump
    i_soft_reset = 1'b1; start = 1'b1; tick();
    i_soft_reset = 1'b0; start = 1'b0;
    tick(); tick();
    chk("start_during_reset", obs_busy, 0);

    run_dump(CP, 10, -1, -1, -1);

    for (int i = 1; i < 16; i++) mem[i] = $urandom;
    run_dump(CP, 0, 4, -1, -1);

    mem[0] = $urandom;
    run_dump(CP, 0, -1, $urandom_range(0, 4 * CP - 1), -1);

    run_dump(CP, 0, -1, -1, 13);
    run_dump(CP, 0, -1, -1, -1);

    sel = 1'b1;
    mem[0] = $urandom;
    run_dump(1, 0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 Parameter CANT_BITS_CONTROL, default 4: width of the word-select bus driven to the pipeline database.
REQ-002 Parameter LONGITUD_INSTRUCCION, default 32: width of the database data word.
REQ-003 Parameter CANT_PALABRAS, default 12: number of database words dumped per request; the select values are 0 to CANT_PALABRAS-1.
REQ-004 Parameter CANT_BITS_UART, default 8: width of the UART transmit byte.
REQ-005 i_clock  in  1  single clock; all state updates occur on its rising edge.
REQ-006 i_soft_reset  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  dump request, sampled only in IDLE.
REQ-008 i_dato  in  LONGITUD_INSTRUCCION  word returned by the database for the current o_control.
REQ-009 o_control  out  CANT_BITS_CONTROL  word select driven to the database.
REQ-010 o_tx_data  out  CANT_BITS_UART  byte presented to the UART transmitter.
REQ-011 o_tx_start  out  1  one-cycle transmit request.
REQ-012 i_tx_done  in  1  UART byte-complete pulse.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_done  out  1  one-cycle end-of-dump pulse.

Function
REQ-015 The FSM states SHALL be IDLE, SETTLE, LATCH, SEND, WAIT_TX, NEXT and DONE.
REQ-016 All outputs SHALL be registered or decoded from state registers, with no combinational path from any input to any output.
REQ-017 IDLE: when i_start=1, the FSM SHALL clear the word index, drive o_control=0 and go to SETTLE.
REQ-018 SETTLE SHALL last exactly one cycle and go to LATCH, giving the database one cycle to present i_dato.
REQ-019 LATCH SHALL capture i_dato into a shift register, clear the byte counter and go to SEND.
REQ-020 SEND SHALL hold o_tx_start=1 for exactly one cycle, with o_tx_data = shift register bits [31:24] (MSB byte first), then go to WAIT_TX.
REQ-021 o_tx_data SHALL remain stable from SEND until the i_tx_done pulse that completes that byte.
REQ-022 WAIT_TX on i_tx_done=1, byte counter below 3: shift the register left by 8, increment the counter, go to SEND.
REQ-023 WAIT_TX on i_tx_done=1, byte counter equal to 3: go to NEXT.
REQ-024 WAIT_TX with i_tx_done=0: stay in WAIT_TX indefinitely, with no timeout.
REQ-025 NEXT, word index equal to CANT_PALABRAS-1: go to DONE.
REQ-026 NEXT, any other word index: increment the index, drive o_control = index+1, go to SETTLE.
REQ-027 DONE SHALL assert o_done=1 for one cycle, drive o_control=0 and return to IDLE.
REQ-028 i_start SHALL be ignored whenever the FSM is not in IDLE, so a dump in progress is never restarted.
REQ-029 i_tx_done SHALL be ignored outside WAIT_TX, including a pulse coincident with o_tx_start.
REQ-030 A complete dump SHALL emit exactly 4*CANT_PALABRAS o_tx_start pulses (48 at defaults), one per i_tx_done.
REQ-031 o_tx_start SHALL be high in the cycle that follows the 3rd rising edge counted from the edge that samples i_start.
REQ-032 The word index SHALL use ceil(log2(CANT_PALABRAS)) bits and SHALL never exceed CANT_PALABRAS-1, so there is no wrap.

Reset
REQ-033 While i_soft_reset=1 at a rising edge, the FSM SHALL go to IDLE and clear o_control, o_tx_data, o_tx_start, o_busy, o_done, the word index, the byte counter and the shift register.
REQ-034 A reset in any state, mid-dump included, SHALL abort the dump without o_done and without any further o_tx_start.
REQ-035 i_start sampled in the same cycle as an active reset SHALL be ignored.

Verification
REQ-036 Database model returning 32'h0A0B0C0D for o_control=0, single i_start, tx_done 10 cycles after each tx_start -> first four bytes 0A, 0B, 0C, 0D in order; o_control steps 0 to 11.
REQ-037 Full dump at defaults -> exactly 48 o_tx_start pulses, one o_done pulse after the 48th i_tx_done, o_busy low the following cycle.
REQ-038 i_start pulsed again during byte 5 -> ignored; pulse count stays 48; one o_done.
REQ-039 i_tx_done asserted in the SEND cycle and held low afterwards -> FSM stays in WAIT_TX, o_tx_data unchanged, no new o_tx_start.
REQ-040 i_soft_reset=1 for one cycle during word 3, byte 2 -> next cycle all outputs 0 and o_busy=0; a new i_start then restarts at o_control=0 and sends the word-0 MSB byte first.
REQ-041 Parameter CANT_PALABRAS=1 -> 4 bytes sent, o_control held at 0 throughout, o_done asserted once.
